// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin and word-wide access to output, direction and
// edge-interrupt registers, with synchronised inputs and a level interrupt.
module gpio_bank #(
  parameter int N    = 64,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_rd,
  input  logic         io_wr,
  input  logic [11:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  input  logic [N-1:0] pin_i,
  output logic [N-1:0] pin_o,
  output logic [N-1:0] pin_oe,
  output logic         irq
);

  localparam int ARM_W = $clog2(SYNC + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC + 1);

  logic [N-1:0] sync_reg [SYNC];
  logic [N-1:0] prev_reg, out_reg, oe_reg, pend_reg, ren_reg, fen_reg;
  logic [N-1:0] out_next, oe_next, pend_next, ren_next, fen_next;
  logic [N-1:0] sync_in;
  logic [ARM_W-1:0] arm_reg;
  logic         armed;
  logic         irq_reg;
  logic [31:0]  rdata_reg, rd_next;
  logic [3:0]   sel;
  logic [6:0]   pin;
  logic [2:0]   word;
  logic [8:0]   wr_sel;
  logic [255:0] in_pad, out_pad, oe_pad, pend_pad, ren_pad, fen_pad;
  logic         unused_addr;

  assign sel         = addr[11:8];
  assign pin         = addr[6:0];
  assign word        = addr[4:2];
  assign unused_addr = ^{addr[7], addr[1:0]};
  assign sync_in     = sync_reg[SYNC-1];
  assign armed       = (arm_reg == ARM_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_sel
      assign wr_sel[gi] = io_wr && (sel == 4'(gi));
    end

    // Per-pin next-state; pins beyond N have no storage, so writes to them vanish.
    for (gi = 0; gi < N; gi++) begin : g_bit
      localparam logic [2:0] WI = 3'(gi / 32);
      localparam int BI = gi % 32;
      logic pin_hit, word_hit, wbit, rise, fall, ev;

      assign pin_hit  = (pin == 7'(gi));
      assign word_hit = (word == WI);
      assign wbit     = wdata[BI];
      assign rise     = sync_in[gi] & ~prev_reg[gi];
      assign fall     = ~sync_in[gi] & prev_reg[gi];
      assign ev       = armed & ((rise & ren_reg[gi]) | (fall & fen_reg[gi]));

      assign out_next[gi] = (wr_sel[0] && pin_hit)          ? wdata[0] :
                            (wr_sel[2] && word_hit)         ? wbit :
                            (wr_sel[4] && word_hit && wbit) ? 1'b1 :
                            (wr_sel[5] && word_hit && wbit) ? 1'b0 :
                            out_reg[gi];
      assign oe_next[gi]  = (wr_sel[1] && pin_hit)  ? wdata[0] :
                            (wr_sel[3] && word_hit) ? wbit : oe_reg[gi];
      assign ren_next[gi] = (wr_sel[7] && word_hit) ? wbit : ren_reg[gi];
      assign fen_next[gi] = (wr_sel[8] && word_hit) ? wbit : fen_reg[gi];
      // A new event wins over a clear of the same bit in the same cycle.
      assign pend_next[gi] = ev | (pend_reg[gi] & ~(wr_sel[6] & word_hit & wbit));
    end
  endgenerate

  assign in_pad   = 256'(sync_in);
  assign out_pad  = 256'(out_reg);
  assign oe_pad   = 256'(oe_reg);
  assign pend_pad = 256'(pend_reg);
  assign ren_pad  = 256'(ren_reg);
  assign fen_pad  = 256'(fen_reg);

  always_comb begin
    rd_next = '0;
    case (sel)
      4'd0:       rd_next = {31'b0, in_pad[{1'b0, pin}]};
      4'd1:       rd_next = {31'b0, oe_pad[{1'b0, pin}]};
      4'd2:       rd_next = in_pad[{word, 5'd0} +: 32];
      4'd3:       rd_next = oe_pad[{word, 5'd0} +: 32];
      4'd4, 4'd5: rd_next = out_pad[{word, 5'd0} +: 32];
      4'd6:       rd_next = pend_pad[{word, 5'd0} +: 32];
      4'd7:       rd_next = ren_pad[{word, 5'd0} +: 32];
      4'd8:       rd_next = fen_pad[{word, 5'd0} +: 32];
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC; k++) sync_reg[k] <= '0;
      prev_reg  <= '0;
      out_reg   <= '0;
      oe_reg    <= '0;
      pend_reg  <= '0;
      ren_reg   <= '0;
      fen_reg   <= '0;
      arm_reg   <= '0;
      rdata_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      sync_reg[0] <= pin_i;
      for (int k = 1; k < SYNC; k++) sync_reg[k] <= sync_reg[k-1];
      prev_reg <= sync_in;
      out_reg  <= out_next;
      oe_reg   <= oe_next;
      pend_reg <= pend_next;
      ren_reg  <= ren_next;
      fen_reg  <= fen_next;
      // Edges are ignored until the chain has flushed its post-reset zeros.
      if (!armed) arm_reg <= arm_reg + 1'b1;
      if (io_rd) rdata_reg <= rd_next;
      irq_reg <= |pend_reg;
    end
  end

  assign rdata  = rdata_reg;
  assign pin_o  = out_reg;
  assign pin_oe = oe_reg;
  assign irq    = irq_reg;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (N=40): register map table plus edge/reset sequences.
module tb_gpio_bank;
  localparam int N    = 40;
  localparam int SYNC = 2;
  localparam int NV   = 34;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_rd, io_wr;
  logic [11:0]   addr;
  logic [31:0]   wdata, rdata;
  logic [N-1:0]  pin_i, pin_o, pin_oe;
  logic          irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rd;
    logic [11:0] a;
    logic [31:0] d;
    logic [39:0] o;
    logic [39:0] oe;
  } vec_t;
  vec_t tbl [NV];

  gpio_bank #(.N(N), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .pin_i(pin_i), .pin_o(pin_o),
    .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    io_wr = 1'b1; addr = a; wdata = d;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    io_rd = 1'b1; addr = a;
    tick();
    io_rd = 1'b0;
    d = rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int irq_seen;

    tbl[0]  = '{0, 12'h300, 32'h0000_00FF, 40'h00_0000_0000, 40'h00_0000_00FF};
    tbl[1]  = '{0, 12'h200, 32'h0000_00A5, 40'h00_0000_00A5, 40'h00_0000_00FF};
    tbl[2]  = '{0, 12'h400, 32'h0000_0100, 40'h00_0000_01A5, 40'h00_0000_00FF};
    tbl[3]  = '{0, 12'h500, 32'h0000_0001, 40'h00_0000_01A4, 40'h00_0000_00FF};
    tbl[4]  = '{1, 12'h400, 32'h0000_01A4, 40'h00_0000_01A4, 40'h00_0000_00FF};
    tbl[5]  = '{1, 12'h500, 32'h0000_01A4, 40'h00_0000_01A4, 40'h00_0000_00FF};
    tbl[6]  = '{1, 12'h300, 32'h0000_00FF, 40'h00_0000_01A4, 40'h00_0000_00FF};
    tbl[7]  = '{0, 12'h027, 32'h0000_0001, 40'h80_0000_01A4, 40'h00_0000_00FF};
    tbl[8]  = '{1, 12'h404, 32'h0000_0080, 40'h80_0000_01A4, 40'h00_0000_00FF};
    tbl[9]  = '{0, 12'h064, 32'h0000_0001, 40'h80_0000_01A4, 40'h00_0000_00FF};
    tbl[10] = '{1, 12'h064, 32'h0000_0000, 40'h80_0000_01A4, 40'h00_0000_00FF};
    tbl[11] = '{1, 12'h027, 32'h0000_0001, 40'h80_0000_01A4, 40'h00_0000_00FF};
    tbl[12] = '{1, 12'h005, 32'h0000_0001, 40'h80_0000_01A4, 40'h00_0000_00FF};
    tbl[13] = '{1, 12'h003, 32'h0000_0000, 40'h80_0000_01A4, 40'h00_0000_00FF};
    tbl[14] = '{0, 12'h127, 32'h0000_0001, 40'h80_0000_01A4, 40'h80_0000_00FF};
    tbl[15] = '{1, 12'h304, 32'h0000_0080, 40'h80_0000_01A4, 40'h80_0000_00FF};
    tbl[16] = '{1, 12'h127, 32'h0000_0001, 40'h80_0000_01A4, 40'h80_0000_00FF};
    tbl[17] = '{0, 12'h204, 32'hFFFF_FFFF, 40'hFF_0000_01A4, 40'h80_0000_00FF};
    tbl[18] = '{1, 12'h204, 32'h0000_00FF, 40'hFF_0000_01A4, 40'h80_0000_00FF};
    tbl[19] = '{1, 12'h200, 32'h0000_0020, 40'hFF_0000_01A4, 40'h80_0000_00FF};
    tbl[20] = '{1, 12'h404, 32'h0000_00FF, 40'hFF_0000_01A4, 40'h80_0000_00FF};
    tbl[21] = '{0, 12'h504, 32'h0000_00F0, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[22] = '{0, 12'h700, 32'hFFFF_FFFF, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[23] = '{1, 12'h700, 32'hFFFF_FFFF, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[24] = '{0, 12'h704, 32'hFFFF_FFFF, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[25] = '{1, 12'h704, 32'h0000_00FF, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[26] = '{0, 12'h900, 32'h0000_FFFF, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[27] = '{1, 12'h900, 32'h0000_0000, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[28] = '{1, 12'h20C, 32'h0000_0000, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[29] = '{0, 12'h800, 32'h0000_0004, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[30] = '{1, 12'h800, 32'h0000_0004, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[31] = '{1, 12'h600, 32'h0000_0000, 40'h0F_0000_01A4, 40'h80_0000_00FF};
    tbl[32] = '{0, 12'h400, 32'h8000_0000, 40'h0F_8000_01A4, 40'h80_0000_00FF};
    tbl[33] = '{0, 12'h500, 32'h8000_0000, 40'h0F_0000_01A4, 40'h80_0000_00FF};

    // Reset state, with pin 5 and pins 39:32 already high.
    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; addr = '0; wdata = '0;
    pin_i = 40'hFF_0000_0020;
    repeat (4) tick();
    check("reset pin_o", 64'(pin_o), 64'h0);
    check("reset pin_oe", 64'(pin_oe), 64'h0);
    check("reset rdata", 64'(rdata), 64'h0);
    check("reset irq", 64'(irq), 64'h0);
    $display("reset done");

    // Pin held high through reset release with rise enabled: no event.
    reset = 1'b0;
    wr(12'h700, 32'h0000_0020);
    irq_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (irq) irq_seen++;
    end
    check("arm irq", 64'(irq_seen), 64'h0);
    rd(12'h600, r);
    check("arm pend", 64'(r), 64'h0);
    $display("arm sequence done");

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rd) begin
        rd(tbl[i].a, r);
        check($sformatf("v%0d rdata", i), 64'(r), 64'(tbl[i].d));
      end else begin
        wr(tbl[i].a, tbl[i].d);
      end
      check($sformatf("v%0d pin_o", i), 64'(pin_o), 64'(tbl[i].o));
      check($sformatf("v%0d pin_oe", i), 64'(pin_oe), 64'(tbl[i].oe));
      $display("vec %0d %s addr=%h data=%h", i, tbl[i].rd ? "rd" : "wr", tbl[i].a, tbl[i].d);
    end

    // Rise on pin 3: pend after SYNC+1 edges, irq one edge later.
    wr(12'h700, 32'h0000_0008);
    pin_i[3] = 1'b1;
    repeat (SYNC + 1) tick();
    check("rise irq early", 64'(irq), 64'h0);
    tick();
    check("rise irq", 64'(irq), 64'h1);
    rd(12'h600, r);
    check("rise pend", 64'(r), 64'h8);
    wr(12'h600, 32'h0000_0008);
    check("w1c irq lag", 64'(irq), 64'h1);
    tick();
    check("w1c irq", 64'(irq), 64'h0);
    rd(12'h600, r);
    check("w1c pend", 64'(r), 64'h0);
    $display("rise sequence done");

    // Fall on pin 2 landing on the same edge as a W1C of bit 2.
    pin_i[2] = 1'b1;
    repeat (6) tick();
    check("no rise irq pin2", 64'(irq), 64'h0);
    pin_i[2] = 1'b0;
    repeat (SYNC) tick();
    wr(12'h600, 32'h0000_0004);
    rd(12'h600, r);
    check("fall vs w1c pend", 64'(r), 64'h4);
    check("fall vs w1c irq", 64'(irq), 64'h1);
    $display("fall/w1c sequence done");

    // Read and write together: old value returned, then rdata held.
    io_rd = 1'b1; io_wr = 1'b1; addr = 12'h300; wdata = 32'h0000_000F;
    tick();
    io_rd = 1'b0; io_wr = 1'b0;
    check("rdwr rdata", 64'(rdata), 64'hFF);
    check("rdwr pin_oe", 64'(pin_oe), 64'h80_0000_000F);
    wdata = 32'h1234_5678; addr = 12'h200;
    repeat (2) tick();
    check("rdata hold", 64'(rdata), 64'hFF);
    $display("rd/wr sequence done");

    // Reset on top of a write and read; pending event is lost.
    reset = 1'b1; io_wr = 1'b1; io_rd = 1'b1; addr = 12'h200; wdata = 32'hFFFF_FFFF;
    tick();
    io_wr = 1'b0; io_rd = 1'b0;
    check("rst wr pin_o", 64'(pin_o), 64'h0);
    check("rst wr rdata", 64'(rdata), 64'h0);
    check("rst wr pin_oe", 64'(pin_oe), 64'h0);
    check("rst wr irq", 64'(irq), 64'h0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    rd(12'h600, r);
    check("rst pend lost", 64'(r), 64'h0);
    check("rst irq after", 64'(irq), 64'h0);
    $display("mid-reset sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter N, default 64: number of GPIO channels; legal range 1..128.
REQ-002 SHALL have parameter SYNC, default 2: input synchroniser depth; legal range 2..4.
REQ-003 SHALL use one clock and a synchronous, active-high reset: port clk, rising edge; port reset, synchronous, active-high.
REQ-004 SHALL have ports in this order: clk in 1 (clock); reset in 1 (sync reset).
REQ-005 SHALL have ports io_rd in 1 (read strobe), io_wr in 1 (write strobe), addr in 12 (local register address), wdata in 32 (write data).
REQ-006 SHALL have ports rdata out 32 (registered read data), pin_i in N (raw pad inputs), pin_o out N (output values), pin_oe out N (1 = drive), irq out 1 (level interrupt).

Function
REQ-007 SHALL decode register select sel = addr[11:8]; for per-pin registers, pin index p = addr[6:0]; for word registers, word index w = addr[4:2] covers pins 32w..32w+31.
REQ-008 SHALL implement this map. sel 0: pin value (read synced input bit p in rdata[0]; write sets out[p] = wdata[0]). sel 1: pin direction (oe[p]). sel 2: input word read / output word write. sel 3: direction word R/W.
REQ-009 SHALL continue the map. sel 4: output set (W1S; read returns output word). sel 5: output clear (W1C; read returns output word). sel 6: event pending (read; W1C). sel 7: rise-enable word R/W. sel 8: fall-enable word R/W. Other sel: read 0, write ignored.
REQ-010 SHALL apply writes in the same cycle as io_wr; registers SHALL show the new value on the next clock.
REQ-011 SHALL capture rdata on the clock edge where io_rd=1 (1-cycle latency) and SHALL hold rdata while io_rd=0.
REQ-012 SHALL read pin/word bits at index >= N as 0 and SHALL ignore writes to them, including p >= N and upper word bits.
REQ-013 SHALL pass pin_i through a SYNC-stage flip-flop chain; sync_in = last stage; prev = sync_in delayed 1 cycle.
REQ-014 SHALL detect rise[i] = sync_in & ~prev and fall[i] = ~sync_in & prev.
REQ-015 SHALL set pend[i] when armed & ((rise[i] & ren[i]) | (fall[i] & fen[i])).
REQ-016 SHALL give a pending set priority over a simultaneous W1C of the same bit: the bit stays 1.
REQ-017 SHALL arm the edge detector via an arm counter that counts SYNC+1 cycles after reset deassertion; edges SHALL be ignored until the count completes, so no spurious events come from reset values.
REQ-018 SHALL register irq = |pend, asserted one cycle after pend becomes nonzero.
REQ-019 SHALL, on a single write with sel 4 or 5, affect only the bits where wdata=1.
REQ-020 SHALL drive pin_o = out and pin_oe = oe directly from registers, with no combinational path from pin_i.
REQ-021 SHALL not affect pin_o/pin_oe when writing direction or enable registers.
REQ-022 SHALL, when io_rd and io_wr are asserted together at the same address, return the pre-write value in rdata.

Reset
REQ-023 SHALL, while reset=1, clear out, oe, pend, ren, fen, all sync stages, prev, rdata, irq and the arm counter to 0.
REQ-024 SHALL, when reset asserts mid-operation, override any io_wr in the same cycle, and pending events SHALL be lost.
REQ-025 SHALL hold all pads undriven (pin_oe=0) from the first reset clock.

Verification
REQ-026 SHALL pass: write sel3 w0 = 0x0000_00FF, sel2 w0 = 0x0000_00A5 -> pin_oe[7:0]=FF, pin_o[7:0]=A5; then sel4 = 0x100, sel5 = 0x1 -> pin_o[8:0]=0x1A4.
REQ-027 SHALL pass: ren[3]=1, pin_i[3] 0->1 -> pend[3]=1 exactly SYNC+1 cycles after the pad change; irq=1 one cycle later; W1C sel6 = 0x8 -> pend=0, irq=0 next cycle.
REQ-028 SHALL pass: pin_i[5]=1 held through reset release, ren[5]=1 -> pend stays 0 and irq stays 0.
REQ-029 SHALL pass: a fall event on pin 2 coincident with a W1C of bit 2 -> pend[2]=1 afterwards.
REQ-030 SHALL pass, with N=40: read sel2 w1 -> bits 31:8 = 0; write sel0 p=100 -> no state change; read sel0 p=100 -> rdata=0.
REQ-031 SHALL pass: reset asserted during an io_wr to sel2 -> pin_o=0 and rdata=0 on the next cycle.
